// File: rtl/led_trail_pwm.sv
// led_trail_pwm: comet-trail brightness stage for a 16-bit rotating-dot pattern.
// Each lit pattern bit loads its channel to full brightness. The level then
// decays by one step every DECAY_DIV enabled cycles and is rendered as PWM.
// Optional build macro LED_TRAIL_GAMMA_EN maps each level through a perceptual
// gamma table before the PWM compare. This requires LEVEL_W = 4.
module led_trail_pwm #(
  parameter int N_LEDS    = 16,
  parameter int LEVEL_W   = 4,
  parameter int DECAY_DIV = 1000000,
  parameter int DIV_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_LEDS-1:0] pattern_in,
  output logic [N_LEDS-1:0] led_out,
  output logic              frame_tick
);

  localparam int                 MAX       = 2**LEVEL_W - 1;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX);
  localparam logic [LEVEL_W-1:0] PWM_LAST  = LEVEL_W'(MAX - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(DECAY_DIV - 1);

  logic [DIV_W-1:0]   prescaler;
  logic               decay_tick;
  logic [LEVEL_W-1:0] pwm_cnt;
  logic [LEVEL_W-1:0] level     [N_LEDS];
  logic [LEVEL_W-1:0] eff_level [N_LEDS];

  // Decay prescaler: counts enabled cycles and wraps every DECAY_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
    end else if (enable) begin
      if (prescaler == DIV_LAST) prescaler <= '0;
      else                       prescaler <= prescaler + 1'b1;
    end
  end

  // One-cycle decay strobe on the last prescaler count of each interval.
  always_comb begin
    decay_tick = enable && (prescaler == DIV_LAST);
  end

  // Per-channel brightness. A pattern load wins over a decay step, even while
  // disabled. Decay saturates at zero.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (rst)                                  level[i] <= '0;
      else if (pattern_in[i])                   level[i] <= LEVEL_MAX;
      else if (decay_tick && level[i] != '0)    level[i] <= level[i] - 1'b1;
    end
  end

  // PWM phase counter: MAX states, so level MAX is always on and level 0 is always off.
  always_ff @(posedge clk) begin
    if (rst)                      pwm_cnt <= '0;
    else if (enable) begin
      if (pwm_cnt == PWM_LAST)    pwm_cnt <= '0;
      else                        pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

`ifdef LED_TRAIL_GAMMA_EN
  if (LEVEL_W != 4) begin : g_gamma_width_check
    $error("led_trail_pwm: LED_TRAIL_GAMMA_EN requires LEVEL_W == 4");
  end

  localparam logic [3:0] GAMMA [16] = '{
    4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3,
    4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15
  };

  // Perceptual brightness map ahead of the PWM comparator.
  always_comb begin
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      eff_level[i] = GAMMA[level[i]];
    end
  end
`else
  // Linear brightness: the level drives the comparator directly.
  always_comb begin
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      eff_level[i] = level[i];
    end
  end
`endif

  // Registered PWM drive and frame-start pulse, both forced dark while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_out    <= '0;
      frame_tick <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_LEDS; i++) begin
        led_out[i] <= enable && (eff_level[i] > pwm_cnt);
      end
      frame_tick <= enable && (pwm_cnt == '0);
    end
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Self-checking bench for led_trail_pwm (DECAY_DIV = 4).
// The reference model tracks the count of enabled cycles since reset. The PWM
// phase and the decay strobe are derived from that count arithmetically.
module tb_led_trail_pwm;

  localparam int N   = 16;
  localparam int DIV = 4;
  localparam int MAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [N-1:0]  pattern_in = '0;
  logic [N-1:0]  led_out;
  logic          frame_tick;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int           en_cnt;
  int           lvl [N];
  logic [N-1:0] exp_led;
  logic         exp_ft;

  led_trail_pwm #(.N_LEDS(16), .LEVEL_W(4), .DECAY_DIV(DIV), .DIV_W(24)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_in(pattern_in),
    .led_out(led_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic int eff(input int l);
`ifdef LED_TRAIL_GAMMA_EN
    int g [16] = '{0, 1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 8, 10, 12, 15};
    return g[l];
`else
    return l;
`endif
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the outputs after the coming edge and advance the model.
  task automatic model_edge(input logic r, input logic e, input logic [N-1:0] p);
    int  pwm;
    bit  tick;
    if (r) begin
      en_cnt  = 0;
      exp_led = '0;
      exp_ft  = 1'b0;
      for (int i = 0; i < N; i++) lvl[i] = 0;
    end else begin
      pwm  = en_cnt % MAX;
      tick = e && (en_cnt % DIV == DIV - 1);
      exp_ft = e && (pwm == 0);
      for (int i = 0; i < N; i++) begin
        exp_led[i] = e && (eff(lvl[i]) > pwm);
        if (p[i])                 lvl[i] = MAX;
        else if (tick && lvl[i] > 0) lvl[i] = lvl[i] - 1;
      end
      if (e) en_cnt++;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [N-1:0] p);
    @(negedge clk);
    rst = r; enable = e; pattern_in = p;
    model_edge(r, e, p);
    @(posedge clk);
    #1;
    chk("led_out", led_out, exp_led);
    chk("frame_tick", {15'b0, frame_tick}, {15'b0, exp_ft});
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, '0);
  endtask

  initial begin
    logic [N-1:0] p;
    int r;

    // 1. Reset held with all pattern bits high.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 16'hFFFF);
      chk("reset_led_lit", led_out, 16'h0000);
      chk("reset_ft_lit", {15'b0, frame_tick}, 16'h0000);
    end
    step(1'b0, 1'b1, 16'hFFFF);
    chk("rel1_led_lit", led_out, 16'h0000);
    chk("rel1_ft_lit", {15'b0, frame_tick}, 16'h0001);
    step(1'b0, 1'b1, 16'hFFFF);
    chk("rel2_led_lit", led_out, 16'hFFFF);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 16'hFFFF);

    // 2. Steady dot.
    do_reset();
    step(1'b0, 1'b1, 16'h8000);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 16'h8000);
      chk("steady_lit", led_out, 16'h8000);
    end

    // 3. Single-cycle dot fades out and stays dark.
    do_reset();
    step(1'b0, 1'b1, 16'h8000);
    step(1'b0, 1'b1, 16'h0000);
    chk("fade_first_lit", led_out, 16'h8000);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 16'h0000);
    chk("fade_done_lit", led_out, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 16'h0000);
      chk("no_wrap_lit", led_out, 16'h0000);
    end

    // 4. Rotation trail.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h8000);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h4000);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 16'h2000);

    // 5. Reload coinciding with a decay strobe.
    do_reset();
    step(1'b0, 1'b1, 16'h0008);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < DIV && (en_cnt % DIV != DIV - 1); i++) step(1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 16'h0008);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 16'h0000);

    // 6. Freeze mid-fade at level 9, resume, then reset mid-fade.
    do_reset();
    step(1'b0, 1'b1, 16'h0100);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 16'h0000);
      chk("freeze_dark_lit", led_out, 16'h0000);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 16'h0000);
    chk("midfade_rst_lit", led_out, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 16'h0000);
      chk("post_rst_dark_lit", led_out, 16'h0000);
    end

    // Randomized run: sparse dots, enable gaps, occasional reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      p = '0;
      else if (r < 90) p = 16'(1 << $urandom_range(0, N - 1));
      else             p = 16'($urandom);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 85), p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_trail_pwm.md
Name: led_trail_pwm

Overview:
- Downstream display stage for the 16-bit rotating-dot pattern generator.
- Turns each one-hot pattern bit into a per-LED brightness level, then drives the LEDs with PWM.
- A lit position is shown at full brightness. When the dot moves away, that LED fades out over a programmable interval, leaving a comet-style trail on the 16 board LEDs.

Parameters:
- N_LEDS, 16, number of LED channels; equals pattern width.
- LEVEL_W, 4, brightness level width; MAX = 2^LEVEL_W - 1 (15).
- DECAY_DIV, 1000000, clk cycles per one-level decay step; must be >= 1.
- DIV_W, 24, prescaler counter width; must satisfy 2^DIV_W >= DECAY_DIV.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; synchronous, active-high.
- enable, input, 1, 1 = run; 0 = outputs dark and decay frozen.
- pattern_in, input, N_LEDS, pattern from the upstream generator; 1 = position currently lit.
- led_out, output, N_LEDS, PWM-modulated LED drive (registered).
- frame_tick, output, 1, one-cycle pulse at the start of each PWM period (registered).

Behaviour:
- Reset (rst=1 at a clk edge):
  - level[i] = 0 for all i; pwm_cnt = 0; prescaler = 0.
  - led_out = 0; frame_tick = 0.
  - Reset mid-fade discards all levels; led_out = 0 on the cycle after the reset edge.
- Prescaler:
  - Counts 0..DECAY_DIV-1 while enable=1, then wraps to 0.
  - decay_tick is high in the cycle where prescaler == DECAY_DIV-1 and enable=1.
  - DECAY_DIV=1 gives decay_tick every enabled cycle.
  - Holds its value while enable=0.
- Level update, per channel, each cycle, in priority order:
  1. pattern_in[i]=1: level[i] <= MAX. This applies regardless of enable, and takes precedence over a simultaneous decay_tick.
  2. decay_tick and level[i] > 0: level[i] <= level[i] - 1. Saturates at 0 and never wraps.
  3. Otherwise level[i] holds.
- PWM counter:
  - pwm_cnt counts 0..MAX-1 (15 states) and wraps, running only while enable=1.
  - Frame period = MAX cycles.
- Output:
  - led_out[i] <= enable & (eff_level[i] > pwm_cnt), where eff_level = level, or the gamma-mapped level (see Optional Feature).
  - Level MAX is a constant 1; level 0 is a constant 0.
  - Duty cycle = eff_level/MAX.
  - frame_tick <= enable & (pwm_cnt == 0).
- Latency: pattern_in[i] rising at edge k gives level = MAX after edge k and led_out[i] = 1 after edge k+1 (2-cycle input-to-output).
- enable=0:
  - led_out and frame_tick go to 0 on the next edge.
  - pwm_cnt, prescaler and decay are frozen; pattern loads still occur.
  - On re-enable, counting resumes from the held values.
- Multiple pattern bits set at once are legal; each channel is independent.

Optional Feature:
- Macro: LED_TRAIL_GAMMA_EN.
- Defined:
  - eff_level = GAMMA[level], where for LEVEL_W=4 the table for levels 0..15 is 0,1,1,1,1,2,2,3,3,4,5,6,8,10,12,15.
  - Implemented as a combinational LUT before the comparator; latency unchanged.
  - Elaboration error if LEVEL_W != 4.
- Not defined: eff_level = level (linear). No LUT logic is present.

Test Plan:
(All scenarios use DECAY_DIV=4, default other parameters, enable=1 unless stated.)
1. Reset: rst=1 for 3 cycles with pattern_in=16'hFFFF -> led_out=16'h0000 and frame_tick=0 during reset. After release: led_out=16'hFFFF from the 2nd cycle; frame_tick pulses every 15 cycles.
2. Steady dot: pattern_in=16'h8000 held -> led_out[15]=1 every cycle from the 2nd cycle; led_out[14:0]=0 throughout.
3. Single-cycle dot: pattern_in=16'h8000 for 1 cycle, then 0 -> level[15] falls by 1 every 4 cycles. led_out[15] high for level-many of each 15-cycle frame (linear build). Constant 0 after 60 cycles, with no wrap back to 15.
4. Rotation: pattern_in 16'h8000 -> 16'h4000 -> 16'h2000, 8 cycles each -> bit 13 at full duty; bits 14 and 15 at successively lower duty (levels 13 and 11 at the 3rd step).
5. Collision: pattern_in[3] reasserted on a decay_tick cycle -> level[3] = 15 (not 14). Level 0 receiving a decay_tick stays 0.
6. Freeze/reset: enable=0 mid-fade at level 9 for 20 cycles -> led_out=0, level still 9 at re-enable, fade resumes. Then rst=1 one cycle mid-fade -> all led_out=0 next cycle, all levels 0.
